onehot_request_gen: RTL and testbench

- Upstream stage of the 8-to-3 priority encoder.
- Synchronises and debounces 8 raw request lines (buttons or event strobes), and records each debounced rising edge as a pending request.
- Presents pending requests one at a time as a clean one-hot vector, held under a valid/ready handshake, so the encoder sees one stable line per transaction.
- Flags requests lost because the same line was still pending.

---
 rtl/onehot_request_gen.sv | 138 +++++++++++++
 tb/tb_onehot_request_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/onehot_request_gen.sv
// Request front end for the 8-to-3 priority encoder: synchronise, debounce,
// latch rising edges as pending, and hand them out one-hot under valid/ready.
module onehot_request_gen #(
  parameter int N_IN   = 8,
  parameter int DB_CNT = 4,
  parameter int CNT_W  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] raw_in,
  output logic [N_IN-1:0] onehot,
  output logic            valid,
  input  logic            ready,
  output logic            overflow,
  input  logic            clr_ovf
);

  typedef enum logic {
    ST_IDLE,
    ST_PRESENT
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DB_CNT - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N_IN-1:0] r_s1;
  logic [N_IN-1:0] r_s2;
  logic [N_IN-1:0] r_stable;
  logic [N_IN-1:0] r_pending;
  logic [CNT_W-1:0] r_cnt [N_IN];

  logic [N_IN-1:0] w_flip;
  logic [N_IN-1:0] w_rise;
  logic [N_IN-1:0] w_lowest;
  logic [N_IN-1:0] w_clr;
  logic [N_IN-1:0] w_onehot_nxt;
  logic            w_valid_nxt;
  logic            w_ovf_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= raw_in;
      r_s2 <= r_s1;
    end
  end

  // A line flips on the edge where its counter would reach DB_CNT.
  always_comb begin
    w_flip = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      w_flip[k] = (r_s2[k] != r_stable[k]) && (r_cnt[k] == LP_LAST);
    end
  end

  assign w_rise = w_flip & r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '0;
      for (int unsigned k = 0; k < N_IN; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < N_IN; k++) begin
        if (r_s2[k] == r_stable[k]) begin
          r_cnt[k] <= '0;
        end else if (w_flip[k]) begin
          r_stable[k] <= r_s2[k];
          r_cnt[k]    <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  // Isolate the lowest set pending bit (index 0 has highest priority).
  assign w_lowest = r_pending & (~r_pending + N_IN'(1));

  always_comb begin
    w_state_nxt  = r_state;
    w_onehot_nxt = onehot;
    w_valid_nxt  = valid;
    w_clr        = '0;
    case (r_state)
      ST_IDLE: begin
        w_onehot_nxt = '0;
        w_valid_nxt  = 1'b0;
        if (|r_pending) begin
          w_onehot_nxt = w_lowest;
          w_valid_nxt  = 1'b1;
          w_clr        = w_lowest;
          w_state_nxt  = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (ready) begin
          w_onehot_nxt = '0;
          w_valid_nxt  = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: begin
        w_onehot_nxt = '0;
        w_valid_nxt  = 1'b0;
        w_state_nxt  = ST_IDLE;
      end
    endcase
  end

  // A rise coinciding with the grant clear re-sets pending and is not a drop.
  assign w_ovf_evt = |(w_rise & r_pending & ~w_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      onehot    <= '0;
      valid     <= 1'b0;
      r_pending <= '0;
      overflow  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      onehot    <= w_onehot_nxt;
      valid     <= w_valid_nxt;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (w_ovf_evt) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_onehot_request_gen.sv
// Directed bench for onehot_request_gen: latency, debounce, priority,
// overflow, asynchronous reset and a per-line sweep.
module tb_onehot_request_gen;

  logic       clk;
  logic       rst_n;
  logic [7:0] raw_in;
  logic [7:0] onehot;
  logic       valid;
  logic       ready;
  logic       overflow;
  logic       clr_ovf;

  int n_pass;
  int n_total;

  onehot_request_gen #(
    .N_IN  (8),
    .DB_CNT(4),
    .CNT_W (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_in  (raw_in),
    .onehot  (onehot),
    .valid   (valid),
    .ready   (ready),
    .overflow(overflow),
    .clr_ovf (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int line);
    logic [7:0] m;
    m = 8'h01 << line;
    raw_in = m;
    tick(8);
    raw_in = '0;
    tick(8);
  endtask

  int         grants;
  int         bad;
  int         inv_err;
  logic [7:0] exp_oh;

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b1;
    raw_in  = '0;
    ready   = 1'b0;
    clr_ovf = 1'b0;
    #2 rst_n = 1'b0;
    tick(2);
    check("rst_onehot", 32'(onehot), 32'h00);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    rst_n = 1'b1;

    // Single request: grant on edge 7, held while ready low.
    raw_in = 8'h04;
    tick(6);
    check("lat_e6_valid", 32'(valid), 32'h0);
    tick(1);
    check("lat_e7_valid", 32'(valid), 32'h1);
    check("lat_e7_onehot", 32'(onehot), 32'h04);
    tick(3);
    raw_in = '0;
    tick(2);
    check("hold_onehot", 32'(onehot), 32'h04);
    check("hold_valid", 32'(valid), 32'h1);
    ready = 1'b1;
    tick(1);
    check("ack_valid", 32'(valid), 32'h0);
    check("ack_onehot", 32'(onehot), 32'h00);
    ready = 1'b0;
    tick(12);
    check("no_regrant", 32'(valid), 32'h0);

    // Glitch of 3 cycles must be ignored.
    raw_in = 8'h20;
    tick(3);
    raw_in = '0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (valid !== 1'b0) bad++;
    end
    check("glitch_valid_cycles", 32'(bad), 32'd0);

    // Simultaneous lines 0 and 7: lower index first, one idle cycle between.
    raw_in = 8'h81;
    ready  = 1'b1;
    tick(7);
    check("sim_g1", 32'(onehot), 32'h01);
    tick(1);
    check("sim_gap", 32'(onehot), 32'h00);
    check("sim_gap_valid", 32'(valid), 32'h0);
    tick(1);
    check("sim_g2", 32'(onehot), 32'h80);
    tick(1);
    check("sim_end", 32'(onehot), 32'h00);
    check("sim_ovf", 32'(overflow), 32'h0);
    raw_in = '0;
    ready  = 1'b0;
    tick(12);

    // Overflow on a presented line.
    pulse(3);
    check("ovf_present", 32'(onehot), 32'h08);
    check("ovf_p1", 32'(overflow), 32'h0);
    pulse(3);
    check("ovf_p2", 32'(overflow), 32'h0);
    check("ovf_p2_hold", 32'(onehot), 32'h08);
    pulse(3);
    check("ovf_p3", 32'(overflow), 32'h1);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    check("ovf_clr", 32'(overflow), 32'h0);
    ready = 1'b1;
    tick(1);
    check("ovf_ack", 32'(valid), 32'h0);
    tick(1);
    check("ovf_regrant", 32'(onehot), 32'h08);
    tick(1);
    ready = 1'b0;
    tick(4);
    check("ovf_idle", 32'(valid), 32'h0);

    // Asynchronous reset while presenting with pending requests.
    raw_in = 8'h10;
    tick(7);
    check("mr_present", 32'(onehot), 32'h10);
    raw_in = 8'h32;
    tick(7);
    check("mr_hold", 32'(onehot), 32'h10);
    #2 rst_n = 1'b0;
    raw_in = '0;
    #1;
    check("mr_onehot", 32'(onehot), 32'h00);
    check("mr_valid", 32'(valid), 32'h0);
    check("mr_ovf", 32'(overflow), 32'h0);
    tick(2);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (valid !== 1'b0) bad++;
    end
    check("mr_no_grant", 32'(bad), 32'd0);

    // Each line alone: exactly one grant of its own bit.
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_oh  = 8'h01 << k;
      grants  = 0;
      bad     = 0;
      inv_err = 0;
      raw_in  = exp_oh;
      for (int i = 0; i < 24; i++) begin
        if (i == 8) raw_in = '0;
        tick(1);
        if ((onehot & (onehot - 8'h01)) != 8'h00) inv_err++;
        if (valid !== (onehot != 8'h00)) inv_err++;
        if (valid === 1'b1) begin
          grants++;
          if (onehot !== exp_oh) bad++;
        end
      end
      check($sformatf("sweep%0d_grants", k), 32'(grants), 32'd1);
      check($sformatf("sweep%0d_code", k), 32'(bad), 32'd0);
      check($sformatf("sweep%0d_inv", k), 32'(inv_err), 32'd0);
    end
    check("sweep_ovf", 32'(overflow), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
